note_sequencer: RTL
===================

// Module: note_sequencer
// PURPOSE
//   Step sequencer that plays a stored melody on the PWM audio voice.
//   Holds a STEPS-entry pattern RAM (frequency, note length, ADSR choice),
//   loaded through a simple write port. On start it walks the pattern at a
//   programmable tempo. It drives the voice's frequency, note-length and
//   ADSR-choice inputs and issues one trigger pulse per note.
//   Sits between the Wishbone/LA config logic and the PWM audio voice.
// PARAMETERS
//   STEPS   16  pattern depth (power of 2); AW = log2(STEPS)
//   FREQ_W  12  frequency word width
//   DIV_W   16  tempo divider width
// PORTS
//   clk             in   1             system clock
//   reset           in   1             asynchronous, active-low reset
//   wr_en           in   1             pattern write strobe
//   wr_addr         in   AW            pattern write address
//   wr_data         in   FREQ_W+6      {freq[FREQ_W-1:0], len[2:0], adsr[2:0]}
//   seq_last        in   AW            index of last step played
//   tempo_div       in   DIV_W         cycles per beat minus 1
//   loop            in   1             1: wrap to step 0 after seq_last
//   start           in   1             pulse: begin playback at step 0
//   stop            in   1             pulse: abort playback
//   io_frequency    out  FREQ_W        frequency to voice (0 = silent)
//   io_note_length  out  3             note length to voice
//   io_adsr_choice  out  3             envelope select to voice
//   io_trigger      out  1             one-cycle note-on pulse
//   busy            out  1             high while not IDLE
//   step_idx        out  AW            step currently fetched or playing
// BEHAVIOUR
//   - Reset (reset=0, async): state IDLE, all outputs 0, beat/len counters 0.
//     Pattern RAM is not cleared.
//   - All outputs are registered.
//   - States:
//     IDLE -start-> FETCH
//     FETCH (1 cycle) -> PLAY
//     PLAY -duration expired-> FETCH (next step) or IDLE
//   - FETCH: load io_frequency, io_note_length and io_adsr_choice from
//     RAM[step_idx]. Counters cleared.
//   - PLAY entry cycle: io_trigger=1 for exactly one cycle if freq!=0.
//     A step with freq==0 is a rest: no trigger, duration still counted.
//   - Duration: PLAY lasts (len+1)*(tempo_div+1) cycles.
//     Beat counter runs 0..tempo_div; the beat counter wraps len+1 times.
//   - Trigger spacing between consecutive notes =
//     (len+1)*(tempo_div+1) + 1 cycles (includes the FETCH cycle).
//   - Expiry with step_idx < seq_last: step_idx+1 -> FETCH.
//   - Expiry with step_idx == seq_last:
//       loop=1 -> step_idx=0, FETCH.
//       loop=0 -> IDLE; io_frequency cleared to 0; other outputs hold.
//   - tempo_div, seq_last and loop are sampled live.
//     seq_last lowered below step_idx: play on to STEPS-1, then apply the
//     wrap rule at STEPS-1 (step_idx wraps mod STEPS).
//   - stop (any state): IDLE next cycle, io_frequency=0, io_trigger=0,
//     step_idx=0.
//   - start while busy: ignored. start and stop in the same cycle: stop wins.
//   - Writes are accepted in any state and land in RAM the same edge.
//     A write to the playing step does not alter outputs until its next FETCH.
//     A write and FETCH to the same address in the same cycle: FETCH reads
//     the old data.
//   - io_trigger is never high in IDLE or FETCH.
// TESTING
//   1. Load steps 0..2 = {100,1,0},{200,0,2},{300,2,5}; seq_last=2,
//      tempo_div=3, loop=0, start.
//      -> triggers at T, T+9, T+14.
//      -> busy drops at T+14+12, io_frequency=0.
//   2. Same pattern, loop=1
//      -> 4th trigger at T+27 with io_frequency=100, step_idx=0.
//   3. Step 1 freq=0 (rest)
//      -> no trigger at T+9; next trigger at T+14; io_frequency=0 for step 1.
//   4. stop pulse mid-PLAY of step 1
//      -> next cycle busy=0, io_frequency=0, step_idx=0; no further triggers.
//   5. start+stop same cycle from IDLE -> stays IDLE.
//      start during PLAY -> no effect on step_idx.
//   6. Assert reset (low) mid-PLAY
//      -> outputs 0 immediately (async).
//      -> after release, start replays pattern intact from step 0.

Source files
------------

// File: rtl/note_sequencer.sv
// Step sequencer: walks a small pattern RAM at a programmable tempo and
// drives frequency / note length / envelope select plus a note-on pulse
// into the PWM audio voice.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | not playing; io_frequency silent, other outputs hold
// FETCH | one cycle: latch RAM[step_idx] onto outputs, clear counters
// PLAY  | count (len+1)*(tempo_div+1) cycles, trigger on first cycle
module note_sequencer #(
  parameter int STEPS  = 16,
  parameter int FREQ_W = 12,
  parameter int DIV_W  = 16,
  localparam int AW    = $clog2(STEPS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [FREQ_W+5:0] wr_data,
  input  logic [AW-1:0]     seq_last,
  input  logic [DIV_W-1:0]  tempo_div,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  output logic [FREQ_W-1:0] io_frequency,
  output logic [2:0]        io_note_length,
  output logic [2:0]        io_adsr_choice,
  output logic              io_trigger,
  output logic              busy,
  output logic [AW-1:0]     step_idx
);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(STEPS - 1);

  state_t             state;
  logic [DIV_W-1:0]   beat_cnt;
  logic [2:0]         len_cnt;
  logic [FREQ_W+5:0]  ram [STEPS];
  logic [FREQ_W+5:0]  rd_word;
  logic [FREQ_W-1:0]  rd_freq;
  logic               beat_wrap;
  logic               note_done;
  logic               last_step;

  // Pattern RAM write port; not reset so a pattern survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wr_addr] <= wr_data;
  end

  // Read is combinational off the registered index, so a same-edge write
  // to the fetched address is seen only on the following fetch.
  assign rd_word   = ram[step_idx];
  assign rd_freq   = rd_word[FREQ_W+5:6];
  assign beat_wrap = (beat_cnt == tempo_div);
  assign note_done = beat_wrap && (len_cnt == io_note_length);
  // seq_last may be moved below the current step; then run to the top and wrap.
  assign last_step = (step_idx == seq_last) || (step_idx == LAST_IDX);

  // Sequencer FSM with registered outputs and beat/length counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      len_cnt        <= '0;
      io_frequency   <= '0;
      io_note_length <= '0;
      io_adsr_choice <= '0;
      io_trigger     <= 1'b0;
      busy           <= 1'b0;
      step_idx       <= '0;
    end else begin
      io_trigger <= 1'b0;
      if (stop) begin
        state        <= IDLE;
        busy         <= 1'b0;
        io_frequency <= '0;
        step_idx     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state    <= FETCH;
              busy     <= 1'b1;
              step_idx <= '0;
            end
          end
          FETCH: begin
            io_frequency   <= rd_freq;
            io_note_length <= rd_word[5:3];
            io_adsr_choice <= rd_word[2:0];
            io_trigger     <= (rd_freq != '0);
            beat_cnt       <= '0;
            len_cnt        <= '0;
            state          <= PLAY;
          end
          PLAY: begin
            if (beat_wrap) begin
              beat_cnt <= '0;
              if (note_done) begin
                if (!last_step) begin
                  step_idx <= step_idx + AW'(1);
                  state    <= FETCH;
                end else if (loop) begin
                  step_idx <= '0;
                  state    <= FETCH;
                end else begin
                  state        <= IDLE;
                  busy         <= 1'b0;
                  io_frequency <= '0;
                end
              end else begin
                len_cnt <= len_cnt + 3'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + DIV_W'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
